// File: rtl/ifm_window_reader.sv
// Walks KSIZE x KSIZE windows over an H x W plane in the IFM RAM and streams the
// fetched words to the PE array through a 2-entry skid FIFO (valid/ready).
module ifm_window_reader #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 10,
    parameter int KSIZE  = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [DIM_W-1:0]  cfg_width_i,
    input  logic [DIM_W-1:0]  cfg_height_i,
    input  logic [1:0]        cfg_stride_i,
    input  logic              wr_active_i,
    output logic [ADDR_W-1:0] bram_rd_addr_o,
    input  logic [DATA_W-1:0] bram_rd_data_i,
    output logic [DATA_W-1:0] ifm_data_o,
    output logic              ifm_valid_o,
    input  logic              ifm_ready_i,
    output logic              ifm_last_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int PW = DIM_W + 2;
    localparam logic [KW-1:0] K_LAST = KW'(KSIZE - 1);
    localparam logic [PW-1:0] K_EXT  = PW'(KSIZE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t            state_q;
    logic              busy_q, done_q;
    logic [PW-1:0]     w_q, h_q, s_q;
    logic [ADDR_W-1:0] sb_q, wb_q, swb_q;
    logic [KW-1:0]     kx_q, ky_q;
    logic [PW-1:0]     px_q, py_q;
    logic [ADDR_W-1:0] line_q, win_q, row_q, cur_q, hold_q;
    logic              inflight_q, inflight_last_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic              fifo_last_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q, count_d;

    logic              pop, issue, win_end, col_more, row_more, degenerate;
    logic [2:0]        occ;
    logic [1:0]        start_s;
    logic [ADDR_W-1:0] start_wb, start_swb, start_base;

    always_comb begin
        pop        = (count_q != 2'd0) && ifm_ready_i;
        // Occupancy net of this cycle's pop keeps one element per cycle at full rate.
        occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == RUN) && !wr_active_i && (occ < 3'd2);
        count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
        win_end    = (kx_q == K_LAST) && (ky_q == K_LAST);
        col_more   = (px_q + s_q + K_EXT) <= w_q;
        row_more   = (py_q + s_q + K_EXT) <= h_q;
        start_s    = (cfg_stride_i == 2'd0) ? 2'd1 : cfg_stride_i;
        start_wb   = ADDR_W'(cfg_width_i) << 2;
        start_base = {cfg_base_i[ADDR_W-1:2], 2'b00};
        degenerate = (cfg_width_i < DIM_W'(KSIZE)) || (cfg_height_i < DIM_W'(KSIZE));
        start_swb  = start_wb;
        case (start_s)
            2'd2:    start_swb = start_wb << 1;
            2'd3:    start_swb = start_wb + (start_wb << 1);
            default: start_swb = start_wb;
        endcase
    end

    // The RAM samples the address on the edge that ends the issue cycle.
    assign bram_rd_addr_o = issue ? cur_q : hold_q;
    assign ifm_valid_o    = (count_q != 2'd0);
    assign ifm_data_o     = fifo_data_q[rd_ptr_q];
    assign ifm_last_o     = ifm_valid_o && fifo_last_q[rd_ptr_q];
    assign busy_o         = busy_q;
    assign done_o         = done_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= '0;
            h_q     <= '0;
            s_q     <= '0;
            sb_q    <= '0;
            wb_q    <= '0;
            swb_q   <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            line_q  <= '0;
            win_q   <= '0;
            row_q   <= '0;
            cur_q   <= '0;
            hold_q  <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && win_end;
            case (state_q)
                IDLE: if (start_i) begin
                    w_q    <= PW'(cfg_width_i);
                    h_q    <= PW'(cfg_height_i);
                    s_q    <= PW'(start_s);
                    sb_q   <= ADDR_W'(start_s) << 2;
                    wb_q   <= start_wb;
                    swb_q  <= start_swb;
                    kx_q   <= '0;
                    ky_q   <= '0;
                    px_q   <= '0;
                    py_q   <= '0;
                    line_q <= start_base;
                    win_q  <= start_base;
                    row_q  <= start_base;
                    cur_q  <= start_base;
                    if (degenerate) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: if (issue) begin
                    hold_q <= cur_q;
                    if (kx_q != K_LAST) begin
                        kx_q  <= kx_q + 1'b1;
                        cur_q <= cur_q + ADDR_W'(4);
                    end else if (ky_q != K_LAST) begin
                        kx_q  <= '0;
                        ky_q  <= ky_q + 1'b1;
                        row_q <= row_q + wb_q;
                        cur_q <= row_q + wb_q;
                    end else if (col_more) begin
                        kx_q  <= '0;
                        ky_q  <= '0;
                        px_q  <= px_q + s_q;
                        win_q <= win_q + sb_q;
                        row_q <= win_q + sb_q;
                        cur_q <= win_q + sb_q;
                    end else if (row_more) begin
                        kx_q   <= '0;
                        ky_q   <= '0;
                        px_q   <= '0;
                        py_q   <= py_q + s_q;
                        line_q <= line_q + swb_q;
                        win_q  <= line_q + swb_q;
                        row_q  <= line_q + swb_q;
                        cur_q  <= line_q + swb_q;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: if (!inflight_q && (count_d == 2'd0)) begin
                    state_q <= FIN;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= bram_rd_data_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_ifm_window_reader.sv
// Scoreboard bench for ifm_window_reader: directed planes, expected words queued at
// start, a negedge monitor pops and compares every accepted element.
module tb_ifm_window_reader;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int DIM_W  = 10;
    localparam int KSIZE  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [DIM_W-1:0]  cfg_width = '0;
    logic [DIM_W-1:0]  cfg_height = '0;
    logic [1:0]        cfg_stride = '0;
    logic              wr_active = 1'b0;
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [DATA_W-1:0] bram_rd_data = '0;
    logic [DATA_W-1:0] ifm_data;
    logic              ifm_valid;
    logic              ifm_ready = 1'b1;
    logic              ifm_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    ifm_window_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .KSIZE(KSIZE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .cfg_base_i(cfg_base), .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
        .cfg_stride_i(cfg_stride), .wr_active_i(wr_active),
        .bram_rd_addr_o(bram_rd_addr), .bram_rd_data_i(bram_rd_data),
        .ifm_data_o(ifm_data), .ifm_valid_o(ifm_valid), .ifm_ready_i(ifm_ready),
        .ifm_last_o(ifm_last), .busy_o(busy), .done_o(done)
    );

    // RAM model: word i holds D000_0000 | i, so each element names its own word address.
    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk) if (!wr_active) bram_rd_data <= mem[bram_rd_addr[11:2]];

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q [$];
    logic [31:0] got [$];
    logic [31:0] log1 [$];
    int          cyc = 0, n_last = 0, done_cnt = 0, last_pop_cyc = 0, done_gap = 0, done_base = 0;
    bit          rand_mode = 1'b0;
    bit          stall_pend = 1'b0;
    logic [32:0] stall_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #2;
        ifm_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (stall_pend) chk("stall_stable", {31'd0, ifm_valid, ifm_last, ifm_data}, {31'd0, 1'b1, stall_word});
            stall_pend = 1'b0;
            if (ifm_valid && ifm_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_elem", {31'd0, ifm_last, ifm_data}, 64'h0);
                end else begin
                    chk("elem", {31'd0, ifm_last, ifm_data}, {31'd0, exp_q.pop_front()});
                end
                $display("t=%0t accept data=%h last=%b", $time, ifm_data, ifm_last);
                got.push_back(ifm_data);
                last_pop_cyc = cyc;
                if (ifm_last) n_last++;
            end else if (ifm_valid) begin
                stall_pend = 1'b1;
                stall_word = {ifm_last, ifm_data};
            end
            if (done) begin
                done_cnt++;
                done_gap = cyc - last_pop_cyc;
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic push_plane(input logic [ADDR_W-1:0] base, input int w, input int h, input int s);
        int se, ow, oh, word;
        logic [ADDR_W-1:0] a;
        se = (s == 0) ? 1 : s;
        if (w < KSIZE || h < KSIZE) return;
        ow = (w - KSIZE) / se + 1;
        oh = (h - KSIZE) / se + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < KSIZE; ky++)
                    for (int kx = 0; kx < KSIZE; kx++) begin
                        word = (oy * se + ky) * w + ox * se + kx;
                        a = {base[ADDR_W-1:2], 2'b00} + ADDR_W'(word * 4);
                        exp_q.push_back({(ky == KSIZE-1) && (kx == KSIZE-1), 32'hD000_0000 | 32'(a[11:2])});
                    end
    endtask

    task automatic start_plane(input logic [ADDR_W-1:0] base, input int w, input int h, input int s);
        push_plane(base, w, h, s);
        got.delete();
        n_last = 0;
        done_base = done_cnt;
        @(posedge clk); #2;
        cfg_base = base; cfg_width = DIM_W'(w); cfg_height = DIM_W'(h); cfg_stride = 2'(s);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic finish_plane(input int elems, input int lasts);
        int t = 0;
        while (done_cnt == done_base && t < 3000) begin
            @(posedge clk); #2;
            t++;
        end
        repeat (3) begin @(posedge clk); #2; end
        chk("done_pulses", 64'(done_cnt - done_base), 64'd1);
        chk("elem_count", 64'(got.size()), 64'(elems));
        chk("last_count", 64'(n_last), 64'(lasts));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("done_after_final_accept", 64'(done_gap), 64'd1);
        chk("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_got(input string name, input int idx, input int word);
        if (got.size() > idx) chk(name, {32'd0, got[idx]}, {32'd0, 32'hD000_0000 | 32'(word)});
        else chk(name, 64'(got.size()), 64'(idx + 1));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_addr", 64'(bram_rd_addr), 64'd0);
        chk("rst_data", 64'(ifm_data), 64'd0);
        chk("rst_valid_last_busy_done", {60'd0, ifm_valid, ifm_last, busy, done}, 64'd0);
    endtask

    initial begin
        int w0 [9];
        int lat;
        bit same;
        logic [ADDR_W-1:0] ref_addr;
        w0 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        for (int i = 0; i < 1024; i++) mem[i] = 32'hD000_0000 | 32'(i);

        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs();
        rst_n = 1'b1;

        // Plane 4x4 stride 1, ready held high
        start_plane(20'h0, 4, 4, 1);
        lat = 0;
        while (!ifm_valid && lat < 10) begin
            @(posedge clk); #2;
            lat++;
        end
        chk("first_valid_latency", 64'(lat), 64'd2);
        finish_plane(36, 4);
        for (int i = 0; i < 9; i++) chk_got("w0_addr", i, w0[i]);
        chk_got("w1_first", 9, 1);
        chk_got("final_addr", 35, 15);
        log1 = got;

        // Plane 5x5 stride 2 at base 0x100
        start_plane(20'h100, 5, 5, 2);
        finish_plane(36, 4);
        chk_got("s2_w1_first", 9, 20'h108 >> 2);
        chk_got("s2_w2_first", 18, 20'h128 >> 2);

        // Random ready, plus a start while busy that must be ignored
        rand_mode = 1'b1;
        start_plane(20'h0, 4, 4, 1);
        repeat (10) begin @(posedge clk); #2; end
        cfg_width = 10'd5; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        finish_plane(36, 4);
        rand_mode = 1'b0;
        same = (got == log1);
        chk("random_ready_seq", {63'd0, same}, 64'd1);

        // Write port busy for 10 cycles mid-run
        start_plane(20'h0, 4, 4, 1);
        repeat (5) begin @(posedge clk); #2; end
        wr_active = 1'b1;
        #1 ref_addr = bram_rd_addr;
        repeat (10) begin
            @(posedge clk); #2;
            chk("wr_addr_frozen", 64'(bram_rd_addr), 64'(ref_addr));
        end
        chk("wr_no_capture", {63'd0, ifm_valid}, 64'd0);
        wr_active = 1'b0;
        finish_plane(36, 4);

        // Degenerate plane 2x8
        done_base = done_cnt;
        @(posedge clk); #2;
        cfg_base = '0; cfg_width = 10'd2; cfg_height = 10'd8; cfg_stride = 2'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("degen_done_busy_valid", {61'd0, done, busy, ifm_valid}, 64'b100);
        @(posedge clk); #2;
        chk("degen_done_single", {63'd0, done}, 64'd0);
        repeat (5) begin @(posedge clk); #2; end
        chk("degen_done_pulses", 64'(done_cnt - done_base), 64'd1);

        // Reset mid-run, then rerun the first plane
        start_plane(20'h0, 4, 4, 1);
        repeat (8) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk_reset_outputs();
        rst_n = 1'b1;
        exp_q.delete();
        start_plane(20'h0, 4, 4, 1);
        finish_plane(36, 4);
        same = (got == log1);
        chk("rerun_seq", {63'd0, same}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ifm_window_reader.md
Name: ifm_window_reader

Overview:
- Read-side controller for the IFM block RAM. It walks KSIZE x KSIZE convolution windows over a stored H x W feature-map plane and drives the RAM read address.
- It absorbs the RAM's fixed 1-cycle read latency and presents the fetched words to the PE array as a valid/ready stream.
- It sits between the IFM RAM read port and the PE input. The IFM loader owns the RAM write port.

Parameters:
ADDR_W, 20, width of RAM read address (byte address, word-aligned)
DATA_W, 32, RAM word width
DIM_W, 10, width of plane width/height config fields
KSIZE, 3, kernel window size (square)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; latches cfg_* and begins traversal (ignored while busy)
cfg_base  input  ADDR_W  byte address of plane word (0,0); bits [1:0] ignored
cfg_width  input  DIM_W  plane width W in words
cfg_height  input  DIM_W  plane height H in rows
cfg_stride  input  2  window stride S (1..3; 0 treated as 1)
wr_active  input  1  RAM write port busy (we high); while high, the RAM performs no read
bram_rd_addr  output  ADDR_W  RAM read byte address
bram_rd_data  input  DATA_W  RAM read data, valid 1 cycle after an issued address
ifm_data  output  DATA_W  window element to PE
ifm_valid  output  1  ifm_data valid
ifm_ready  input  1  PE accepts when ifm_valid and ifm_ready both high
ifm_last  output  1  high with the final element (ky=kx=KSIZE-1) of each window
busy  output  1  traversal in progress
done  output  1  one-cycle pulse after the last element of the plane is accepted

Behaviour:
- Reset (rst_n low at clk edge) clears all state from any state, including mid-traversal. State→IDLE, skid buffer and in-flight flag cleared.
- Output reset values: bram_rd_addr=0, ifm_data=0, ifm_valid=0, ifm_last=0, busy=0, done=0.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: on start → RUN, busy=1. Config is latched on the same edge.
  - Degenerate plane (W<KSIZE or H<KSIZE): start → FIN directly, with no reads and no output.
  - RUN: address issue proceeds. After the last address issues → DRAIN.
  - DRAIN: waits until the in-flight read has returned and the buffer is empty → FIN.
  - FIN: done=1 for exactly one cycle, busy drops to 0 in the same cycle, next state IDLE.
- Output grid: OW=(W-KSIZE)/S+1, OH=(H-KSIZE)/S+1, integer floor.
- Loop order, outermost first: oy, ox, ky, kx.
- Address: word = (oy*S+ky)*W + (ox*S+kx); bram_rd_addr = cfg_base + (word<<2).
  - Computed in ADDR_W bits; overflow wraps modulo 2^ADDR_W.
  - Use incremental counters/adders only; no multiplier required.
- Issue rule: an address is issued in a cycle only if all of the following hold: state RUN, wr_active=0, and (buffer occupancy + in-flight) < 2.
  - bram_rd_addr changes only on issue; otherwise it holds its value.
  - An issued read returns on the next edge; bram_rd_data is captured into the tail of the 2-entry FIFO together with its last flag.
- Output stream:
  - ifm_valid = buffer non-empty; ifm_data/ifm_last come from the buffer head.
  - Pop on ifm_valid & ifm_ready.
  - Data and last must stay stable while ifm_valid=1 and ifm_ready=0.
  - No word is lost or duplicated under any ready/wr_active pattern.
- Throughput: with ifm_ready=1 and wr_active=0, one element per cycle. Latency from start to first ifm_valid is 2 cycles.
- Simultaneous events:
  - A capture and a pop in the same cycle keep the occupancy unchanged.
  - start during busy is ignored.
  - start in the done cycle is ignored.
- Total elements per plane = OH*OW*KSIZE*KSIZE; ifm_last asserts OH*OW times.

Test Plan:
- W=4,H=4,S=1,base=0, ready=1 → 36 elements, 4 last pulses.
  - Window 0 addrs 0,4,8,16,20,24,32,36,40.
  - Window 1 starts at 4; final addr 60; done 1 cycle after final accept.
- W=5,H=5,S=2,base=0x100 → 4 windows. Window 1 first addr 0x108; window 2 first addr 0x128; 36 elements total.
- Same as first test with ifm_ready pseudo-random 50% → data sequence identical to the ready=1 run; ifm_data stable during every stall; no more than 2 reads outstanding+buffered.
- wr_active held high 10 cycles mid-RUN → bram_rd_addr frozen, no new captures; stream resumes in order with no gap corruption.
- W=2,H=8,start → no ifm_valid; done pulses exactly once, 1 cycle after start.
- rst_n low for 1 cycle mid-RUN, then new start with W=4,H=4 → all outputs at reset values; the new run reproduces the first test's sequence exactly.
